// File: rtl/adder_arbiter.sv
// Two-requester arbiter in front of one shared external W-bit adder; each grant runs IDLE->CALC->RESP.
// Define ADDER_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise req0 has fixed priority.
module adder_arbiter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    input  logic [W-1:0] req0_x,
    input  logic [W-1:0] req0_y,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [W-1:0] req1_x,
    input  logic [W-1:0] req1_y,
    output logic         req1_ready,
    output logic [W-1:0] add_x,
    output logic [W-1:0] add_y,
    input  logic [W-1:0] add_s,
    input  logic         add_c,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W:0]   rsp_sum,
    output logic         rsp_id
);

    typedef enum logic [1:0] {StIdle, StCalc, StResp} state_e;

    state_e       state_q, state_d;
    logic [W-1:0] op_x_q, op_x_d;
    logic [W-1:0] op_y_q, op_y_d;
    logic         grant_q, grant_d;
    logic [W:0]   sum_q, sum_d;
    logic         id_q, id_d;
    logic         pick1;
    logic         ready0, ready1;
`ifdef ADDER_ARB_ROUND_ROBIN_EN
    logic         prio_q, prio_d;
`endif

    // pick1 is only meaningful when at least one requester is valid
    always_comb begin
`ifdef ADDER_ARB_ROUND_ROBIN_EN
        pick1 = req1_valid & (~req0_valid | prio_q);
`else
        pick1 = ~req0_valid;
`endif
    end

    always_comb begin
        state_d   = state_q;
        op_x_d    = op_x_q;
        op_y_d    = op_y_q;
        grant_d   = grant_q;
        sum_d     = sum_q;
        id_d      = id_q;
        ready0    = 1'b0;
        ready1    = 1'b0;
        add_x     = '0;
        add_y     = '0;
        rsp_valid = 1'b0;
`ifdef ADDER_ARB_ROUND_ROBIN_EN
        prio_d    = prio_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (req0_valid || req1_valid) begin
                    grant_d = pick1;
                    ready0  = ~pick1;
                    ready1  = pick1;
                    op_x_d  = pick1 ? req1_x : req0_x;
                    op_y_d  = pick1 ? req1_y : req0_y;
`ifdef ADDER_ARB_ROUND_ROBIN_EN
                    prio_d  = ~pick1;
`endif
                    state_d = StCalc;
                end
            end
            StCalc: begin
                add_x   = op_x_q;
                add_y   = op_y_q;
                sum_d   = {add_c, add_s};
                id_d    = grant_q;
                state_d = StResp;
            end
            StResp: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Ready is combinational from IDLE, so it must be masked while reset is held
    assign req0_ready = ready0 & rst_n;
    assign req1_ready = ready1 & rst_n;
    assign rsp_sum    = sum_q;
    assign rsp_id     = id_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            op_x_q  <= '0;
            op_y_q  <= '0;
            grant_q <= 1'b0;
            sum_q   <= '0;
            id_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_x_q  <= op_x_d;
            op_y_q  <= op_y_d;
            grant_q <= grant_d;
            sum_q   <= sum_d;
            id_q    <= id_d;
        end
    end

`ifdef ADDER_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end
`endif

endmodule
